// File: rtl/countdown_pkg.sv
// Shared types for the retry timer controller and its helpers.
//   rtc_state_t  : controller FSM states
//   rtc_result_t : latched transaction outcome (ok / abort / retries used)
// The retries field is sized for the largest legal retry budget (255).

package countdown_pkg;

    localparam int unsigned RTC_RW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } rtc_state_t;

    typedef struct packed {
        logic              ok;
        logic              abort;
        logic [RTC_RW-1:0] retries;
    } rtc_result_t;

endpackage

// File: rtl/retry_timer_ctrl_prescaler.sv
// tick_prescaler: divides the clock into countdown enable ticks.
//   clock, i_reset : clock and synchronous active-high reset
//   clear          : zero the phase counter (start of an attempt)
//   run            : advance the phase counter this cycle
//   tick           : high on the cycle the phase counter wraps
// With clear applied the cycle before run starts, the first tick lands on
// the PRESCALE-th run cycle and then every PRESCALE cycles.

module tick_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clock,
    input  logic i_reset,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int unsigned   PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_count;
    logic          w_wrap;

    assign w_wrap = (r_count == LAST);

    always_ff @(posedge clock) begin
        if (i_reset || clear) begin
            r_count <= '0;
        end else if (run) begin
            r_count <= w_wrap ? '0 : r_count + 1'b1;
        end
    end

    assign tick = run && w_wrap;

endmodule

// File: rtl/retry_timer_ctrl.sv
// retry_timer_ctrl: issues a transaction, waits for an acknowledge under a
// countdown timeout and retries up to MAX_RETRIES times before reporting.
//   clock, i_reset                  : clock, synchronous active-high reset
//   i_req_valid / o_req_ready       : request handshake (ready only in IDLE)
//   i_abort                         : cancel the in-flight transaction
//   o_tx_start                      : one-cycle pulse per attempt
//   i_tx_ack                        : far-side acknowledge
//   o_cnt_reset / o_cnt_enable      : drive the external countdown
//   i_cnt_done                      : countdown done flag
//   o_result_valid / i_result_ready : result handshake
//   o_result_ok / o_result_abort / o_result_retries : latched outcome

module retry_timer_ctrl
    import countdown_pkg::*;
#(
    parameter int unsigned MAX_RETRIES = 3,
    parameter int unsigned PRESCALE    = 1,
    parameter int unsigned RW          = 8
) (
    input  logic          clock,
    input  logic          i_reset,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_abort,
    output logic          o_tx_start,
    input  logic          i_tx_ack,
    output logic          o_cnt_reset,
    output logic          o_cnt_enable,
    input  logic          i_cnt_done,
    output logic          o_result_valid,
    input  logic          i_result_ready,
    output logic          o_result_ok,
    output logic          o_result_abort,
    output logic [RW-1:0] o_result_retries
);

    localparam logic [RW-1:0] MAXR = RW'(MAX_RETRIES);

    rtc_state_t    r_state;
    logic [RW-1:0] r_retries;
    rtc_result_t   r_result;

    logic w_arm;
    logic w_wait;

    assign w_arm  = (r_state == ARM);
    assign w_wait = (r_state == WAIT);

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock   (clock),
        .i_reset (i_reset),
        .clear   (w_arm),
        .run     (w_wait),
        .tick    (o_cnt_enable)
    );

    // Done from the countdown is only trusted in WAIT: during ARM it may still
    // be the stale flag of the previous attempt until the reset takes effect.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_retries <= '0;
            r_result  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req_valid) begin
                        r_retries <= '0;
                        r_state   <= ARM;
                    end
                end
                ARM: begin
                    if (i_abort) begin
                        r_result.ok      <= 1'b0;
                        r_result.abort   <= 1'b1;
                        r_result.retries <= RTC_RW'(r_retries);
                        r_state          <= RESULT;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_abort) begin
                        r_result.ok      <= 1'b0;
                        r_result.abort   <= 1'b1;
                        r_result.retries <= RTC_RW'(r_retries);
                        r_state          <= RESULT;
                    end else if (i_tx_ack) begin
                        r_result.ok      <= 1'b1;
                        r_result.abort   <= 1'b0;
                        r_result.retries <= RTC_RW'(r_retries);
                        r_state          <= RESULT;
                    end else if (i_cnt_done) begin
                        if (r_retries == MAXR) begin
                            r_result.ok      <= 1'b0;
                            r_result.abort   <= 1'b0;
                            r_result.retries <= RTC_RW'(r_retries);
                            r_state          <= RESULT;
                        end else begin
                            r_retries <= r_retries + 1'b1;
                            r_state   <= ARM;
                        end
                    end
                end
                RESULT: begin
                    if (i_result_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The countdown is held in reset alongside this block so it never runs
    // with a stale count after a controller reset.
    assign o_cnt_reset      = i_reset || w_arm;
    assign o_tx_start       = w_arm;
    assign o_req_ready      = (r_state == IDLE);
    assign o_result_valid   = (r_state == RESULT);
    assign o_result_ok      = r_result.ok;
    assign o_result_abort   = r_result.abort;
    assign o_result_retries = RW'(r_result.retries);

endmodule
